// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one word-aligned bus transaction per access.
// Optional BUS_TIMEOUT_EN bounds the wait for bus_ready in REQ.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        mem_exc,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_wstrb;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_load_data;
  logic        r_load;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;

  logic        w_req;
  logic        w_load;
  logic        w_f3_ok;
  logic        w_misal;
  logic        w_legal;
  logic        w_start;
  logic        w_tmo;
  logic        w_tmo_resp;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // A store wins when both MemRead and MemWrite are set
  assign w_req   = MemRead | MemWrite;
  assign w_load  = MemRead & ~MemWrite;
  assign w_misal = ((funct3[1:0] == 2'b01) & addr[0]) |
                   ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  assign w_legal = w_f3_ok & ~w_misal;
  assign w_start = (r_state == S_IDLE) & w_req & w_legal;

  // Legal funct3 encodings; unsigned sizes exist for loads only
  always_comb begin
    w_f3_ok = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = w_load;
      default:                w_f3_ok = 1'b0;
    endcase
  end

  // Store lane placement: strobes follow the offset, data is replicated
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = 32'h0;
    case (funct3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << addr[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_wstrb = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data[15:0]}};
      end
      2'b10: begin
        w_wstrb = 4'b1111;
        w_wdata = store_data;
      end
      default: begin
        w_wstrb = 4'b0000;
        w_wdata = 32'h0;
      end
    endcase
  end

  assign w_byte = bus_rdata[{r_off, 3'b000} +: 8];
  assign w_half = bus_rdata[{r_off[1], 4'b0000} +: 16];

  // Load lane extraction and sign/zero extension
  always_comb begin
    w_ext = bus_rdata;
    case (r_f3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'h0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'h0, w_half};
      default: w_ext = bus_rdata;
    endcase
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CW-1:0] r_cnt;
  logic          r_tmo;

  assign w_tmo = (r_state == S_REQ) & ~bus_ready &
                 (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_tmo_resp = r_tmo;

  // Count REQ cycles without bus_ready; remember a timeout for RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else if (w_start) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else if ((r_state == S_REQ) & ~bus_ready) begin
      r_cnt <= r_cnt + 1'b1;
      r_tmo <= w_tmo;
    end
  end
`else
  logic [31:0] w_unused_tmo;

  assign w_unused_tmo = 32'(TIMEOUT_CYCLES);
  assign w_tmo        = 1'b0;
  assign w_tmo_resp   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: RESP always returns to IDLE so nothing is reissued
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_next = S_REQ;
      S_REQ:   if (bus_ready | w_tmo) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Combinational handshake and exception outputs
  always_comb begin
    stall      = 1'b0;
    load_valid = 1'b0;
    mem_exc    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        stall   = w_start;
        mem_exc = w_req & ~w_legal;
      end
      S_REQ: stall = 1'b1;
      S_RESP: begin
        load_valid = r_load & ~w_tmo_resp;
        mem_exc    = w_tmo_resp;
      end
      default: stall = 1'b0;
    endcase
  end

  // Registered bus fields and load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_wstrb <= 4'h0;
      r_bus_wdata <= 32'h0;
      r_load_data <= 32'h0;
      r_load      <= 1'b0;
      r_f3        <= 3'b000;
      r_off       <= 2'b00;
    end else begin
      r_bus_req <= (w_next == S_REQ);
      if (w_start) begin
        r_bus_we    <= MemWrite;
        r_bus_addr  <= {addr[31:2], 2'b00};
        r_bus_wstrb <= MemWrite ? w_wstrb : 4'b0000;
        r_bus_wdata <= MemWrite ? w_wdata : 32'h0;
        r_load      <= w_load;
        r_f3        <= funct3;
        r_off       <= addr[1:0];
      end
      if ((r_state == S_REQ) & bus_ready & r_load)
        r_load_data <= w_ext;
      else if (w_tmo)
        r_load_data <= 32'h0;
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wstrb = r_bus_wstrb;
  assign bus_wdata = r_bus_wdata;
  assign load_data = r_load_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads, exceptions, reset.
// Build with BUS_TIMEOUT_EN to also cover the bus timeout path.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        mem_exc;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int checks;
  int errors;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .funct3(funct3),
    .addr(addr),
    .store_data(store_data),
    .stall(stall),
    .load_data(load_data),
    .load_valid(load_valid),
    .mem_exc(mem_exc),
    .bus_req(bus_req),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata),
    .bus_ready(bus_ready),
    .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] exp);
    MemRead = 1'b1;
    funct3  = f3;
    addr    = a;
    #1;
    chk({tag, "_stall_idle"}, 32'(stall), 32'd1);
    tick();
    MemRead   = 1'b0;
    bus_ready = 1'b1;
    #1;
    chk({tag, "_req"}, 32'(bus_req), 32'd1);
    chk({tag, "_we"}, 32'(bus_we), 32'd0);
    chk({tag, "_wstrb"}, 32'(bus_wstrb), 32'd0);
    chk({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
    tick();
    chk({tag, "_valid"}, 32'(load_valid), 32'd1);
    chk({tag, "_data"}, load_data, exp);
    chk({tag, "_stall_resp"}, 32'(stall), 32'd0);
    chk({tag, "_req_resp"}, 32'(bus_req), 32'd0);
    bus_ready = 1'b0;
    tick();
    chk({tag, "_valid_pulse"}, 32'(load_valid), 32'd0);
  endtask

  task automatic do_illegal(input string tag, input logic rd,
                            input logic wr, input logic [2:0] f3,
                            input logic [31:0] a);
    MemRead  = rd;
    MemWrite = wr;
    funct3   = f3;
    addr     = a;
    #1;
    chk({tag, "_exc"}, 32'(mem_exc), 32'd1);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_req"}, 32'(bus_req), 32'd0);
    tick();
    chk({tag, "_req_next"}, 32'(bus_req), 32'd0);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    #1;
    chk({tag, "_exc_clr"}, 32'(mem_exc), 32'd0);
  endtask

  initial begin
    int stall_cnt;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    funct3     = 3'b000;
    addr       = 32'h0;
    store_data = 32'h0;
    bus_ready  = 1'b0;
    bus_rdata  = 32'h0;
    #12;
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wstrb", 32'(bus_wstrb), 32'd0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_ldata", load_data, 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_valid", 32'(load_valid), 32'd0);
    chk("rst_exc", 32'(mem_exc), 32'd0);
    rst = 1'b0;
    tick();

    // SB 0xAB at 0x1003, two wait cycles
    stall_cnt  = 0;
    MemWrite   = 1'b1;
    funct3     = 3'b000;
    addr       = 32'h0000_1003;
    store_data = 32'h0000_00AB;
    #1;
    if (stall) stall_cnt++;
    tick();
    MemWrite = 1'b0;
    chk("sb_req", 32'(bus_req), 32'd1);
    chk("sb_addr", bus_addr, 32'h0000_1000);
    chk("sb_wstrb", 32'(bus_wstrb), 32'b1000);
    chk("sb_wdata", bus_wdata, 32'hABAB_ABAB);
    chk("sb_we", 32'(bus_we), 32'd1);
    if (stall) stall_cnt++;
    tick();
    if (stall) stall_cnt++;
    chk("sb_hold_addr", bus_addr, 32'h0000_1000);
    bus_ready = 1'b1;
    #1;
    if (stall) stall_cnt++;
    tick();
    chk("sb_stall_cycles", 32'(stall_cnt), 32'd4);
    chk("sb_stall_resp", 32'(stall), 32'd0);
    chk("sb_valid", 32'(load_valid), 32'd0);
    chk("sb_exc", 32'(mem_exc), 32'd0);
    bus_ready = 1'b0;
    tick();
    chk("sb_idle_stall", 32'(stall), 32'd0);

    // Loads from word 0x1234F678
    bus_rdata = 32'h1234_F678;
    do_load("lb",  3'b000, 32'h0000_2001, 32'hFFFF_FFF6);
    do_load("lbu", 3'b100, 32'h0000_2001, 32'h0000_00F6);
    do_load("lh",  3'b001, 32'h0000_2002, 32'h0000_1234);
    do_load("lhu", 3'b101, 32'h0000_2000, 32'h0000_F678);
    do_load("lw",  3'b010, 32'h0000_2000, 32'h1234_F678);
    do_load("lb3", 3'b000, 32'h0000_2003, 32'h0000_0012);
    do_load("lh0", 3'b001, 32'h0000_2000, 32'hFFFF_F678);

    // Misaligned and illegal accesses
    do_illegal("mis_lw", 1'b1, 1'b0, 3'b010, 32'h0000_2002);
    do_illegal("mis_sh", 1'b0, 1'b1, 3'b001, 32'h0000_2001);
    do_illegal("ill_ld", 1'b1, 1'b0, 3'b011, 32'h0000_2000);
    do_illegal("ill_st", 1'b0, 1'b1, 3'b100, 32'h0000_2000);

    // MemRead and MemWrite together: store wins
    MemRead    = 1'b1;
    MemWrite   = 1'b1;
    funct3     = 3'b010;
    addr       = 32'h0000_3000;
    store_data = 32'hDEAD_BEEF;
    #1;
    chk("both_stall", 32'(stall), 32'd1);
    tick();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    chk("both_we", 32'(bus_we), 32'd1);
    chk("both_wstrb", 32'(bus_wstrb), 32'b1111);
    chk("both_wdata", bus_wdata, 32'hDEAD_BEEF);
    chk("both_addr", bus_addr, 32'h0000_3000);
    bus_ready = 1'b1;
    tick();
    chk("both_valid", 32'(load_valid), 32'd0);
    chk("both_ldata_kept", load_data, 32'hFFFF_F678);
    bus_ready = 1'b0;
    tick();

    // SH upper half lanes
    MemWrite   = 1'b1;
    funct3     = 3'b001;
    addr       = 32'h0000_3006;
    store_data = 32'h5555_1234;
    tick();
    MemWrite = 1'b0;
    chk("sh_wstrb", 32'(bus_wstrb), 32'b1100);
    chk("sh_wdata", bus_wdata, 32'h1234_1234);
    chk("sh_addr", bus_addr, 32'h0000_3004);
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    tick();

    // Reset in the middle of a request
    MemRead = 1'b1;
    funct3  = 3'b010;
    addr    = 32'h0000_4000;
    tick();
    MemRead = 1'b0;
    chk("mid_req_before", 32'(bus_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_req_async", 32'(bus_req), 32'd0);
    chk("mid_stall", 32'(stall), 32'd0);
    #2;
    rst = 1'b0;
    do_load("after_rst", 3'b010, 32'h0000_4004, 32'h1234_F678);

`ifdef BUS_TIMEOUT_EN
    // LW that never sees bus_ready
    MemRead = 1'b1;
    funct3  = 3'b010;
    addr    = 32'h0000_5000;
    tick();
    MemRead = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("tmo_req%0d", i), 32'(bus_req), 32'd1);
      tick();
    end
    chk("tmo_req_drop", 32'(bus_req), 32'd0);
    chk("tmo_exc", 32'(mem_exc), 32'd1);
    chk("tmo_valid", 32'(load_valid), 32'd0);
    chk("tmo_stall", 32'(stall), 32'd0);
    chk("tmo_ldata", load_data, 32'h0);
    tick();
    chk("tmo_exc_clr", 32'(mem_exc), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
